// File: rtl/fifo_ctrl_arb_pkg.sv
// Shared FIFO geometry defaults and the round-robin grant encoding,
// used by fifo_mem, fifo_ctrl_arb and rr_arb2.
package fifo_ctrl_arb_pkg;

    localparam int FIFO_WIDTH = 8;
    localparam int FIFO_ADDR  = 3;
    localparam int FIFO_DEPTH = 8;

    typedef enum logic [1:0] {
        GNT_NONE = 2'b00,
        GNT_0    = 2'b01,
        GNT_1    = 2'b10
    } gnt_e;

    // last0 = 1 means requester 0 won most recently, so requester 1 wins a tie
    function automatic gnt_e rr_pick(input logic [1:0] req, input logic last0);
        gnt_e g;
        case (req)
            2'b01:   g = GNT_0;
            2'b10:   g = GNT_1;
            2'b11:   g = last0 ? GNT_1 : GNT_0;
            default: g = GNT_NONE;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; owns the "who won last" register.
module rr_arb2
    import fifo_ctrl_arb_pkg::*;
(
    input  logic       wclk,
    input  logic       rst,
    input  logic       flush,
    input  logic       enable,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic last_r;
    gnt_e pick_s;

    // combinational grant selection, suppressed when writes are not eligible
    always_comb begin
        pick_s = GNT_NONE;
        if (enable) begin
            pick_s = rr_pick(req, last_r);
        end else begin
            pick_s = GNT_NONE;
        end
    end

    assign gnt = pick_s;

    // remember the winner; only a real grant moves the fairness pointer
    always_ff @(posedge wclk or negedge rst) begin
        if (!rst) begin
            last_r <= 1'b0;
        end else if (flush) begin
            last_r <= 1'b0;
        end else if (pick_s != GNT_NONE) begin
            last_r <= (pick_s == GNT_0);
        end else begin
            last_r <= last_r;
        end
    end

endmodule

// File: rtl/fifo_ctrl_arb.sv
// FIFO controller for fifo_mem: pointers, status, error pulses and a
// round-robin shared write port for two producers.
module fifo_ctrl_arb
    import fifo_ctrl_arb_pkg::*;
#(
    parameter int WIDTH = FIFO_WIDTH,
    parameter int ADDR  = FIFO_ADDR,
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic             wclk,
    input  logic             rst,
    input  logic             flush,
    input  logic             req0,
    input  logic [WIDTH-1:0] wdata0,
    input  logic             req1,
    input  logic [WIDTH-1:0] wdata1,
    output logic             gnt0,
    output logic             gnt1,
    input  logic             rinc,
    output logic             mem_wen,
    output logic [ADDR-1:0]  mem_waddr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic [ADDR-1:0]  mem_raddr,
    output logic             full,
    output logic             empty,
    output logic [ADDR:0]    count,
    output logic             ovf_err,
    output logic             udf_err
);

    if (DEPTH != (2 ** ADDR)) begin : g_bad_depth
        $error("fifo_ctrl_arb: DEPTH must equal 2**ADDR");
    end

    logic [ADDR:0] wptr_r;
    logic [ADDR:0] rptr_r;
    logic [1:0]    gnt_s;
    logic          full_s;
    logic          empty_s;
    logic          arb_en_s;
    logic          wr_s;
    logic          rd_s;
    logic          ovf_r;
    logic          udf_r;

    assign empty_s = (wptr_r == rptr_r);
    assign full_s  = (wptr_r[ADDR] != rptr_r[ADDR]) &&
                     (wptr_r[ADDR-1:0] == rptr_r[ADDR-1:0]);

    // rst gates the grant so the write port is quiet during reset
    assign arb_en_s = rst && !full_s && !flush;

    rr_arb2 u_arb (
        .wclk   (wclk),
        .rst    (rst),
        .flush  (flush),
        .enable (arb_en_s),
        .req    ({req1, req0}),
        .gnt    (gnt_s)
    );

    assign wr_s = gnt_s[0] | gnt_s[1];
    assign rd_s = rinc && !empty_s && !flush;

    // write-data mux: granted producer, else requester 0, zero in reset
    always_comb begin
        mem_wdata = '0;
        if (!rst) begin
            mem_wdata = '0;
        end else if (gnt_s[1]) begin
            mem_wdata = wdata1;
        end else begin
            mem_wdata = wdata0;
        end
    end

    // pointer update; flush wins over any write or pop in the same cycle
    always_ff @(posedge wclk or negedge rst) begin
        if (!rst) begin
            wptr_r <= '0;
            rptr_r <= '0;
        end else if (flush) begin
            wptr_r <= '0;
            rptr_r <= '0;
        end else begin
            wptr_r <= wptr_r + {{ADDR{1'b0}}, wr_s};
            rptr_r <= rptr_r + {{ADDR{1'b0}}, rd_s};
        end
    end

    // one-cycle error pulses judged on pre-edge status
    always_ff @(posedge wclk or negedge rst) begin
        if (!rst) begin
            ovf_r <= 1'b0;
            udf_r <= 1'b0;
        end else begin
            ovf_r <= !flush && full_s && (req0 || req1);
            udf_r <= !flush && rinc && empty_s;
        end
    end

    assign gnt0      = gnt_s[0];
    assign gnt1      = gnt_s[1];
    assign mem_wen   = wr_s;
    assign mem_waddr = wptr_r[ADDR-1:0];
    assign mem_raddr = rptr_r[ADDR-1:0];
    assign full      = full_s;
    assign empty     = empty_s;
    assign count     = wptr_r - rptr_r;
    assign ovf_err   = ovf_r;
    assign udf_err   = udf_r;

endmodule

// File: tb/tb_fifo_ctrl_arb.sv
// Table-driven bench for fifo_ctrl_arb with a memory model and data scoreboard.
module tb_fifo_ctrl_arb;

    logic       wclk = 1'b0;
    logic       rst;
    logic       flush;
    logic       req0, req1, rinc;
    logic [7:0] wdata0, wdata1;
    logic       gnt0, gnt1, mem_wen, full, empty, ovf_err, udf_err;
    logic [2:0] mem_waddr, mem_raddr;
    logic [7:0] mem_wdata;
    logic [3:0] count;

    fifo_ctrl_arb #(.WIDTH(8), .ADDR(3), .DEPTH(8)) dut (
        .wclk(wclk), .rst(rst), .flush(flush),
        .req0(req0), .wdata0(wdata0), .req1(req1), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rinc(rinc),
        .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .mem_raddr(mem_raddr), .full(full), .empty(empty), .count(count),
        .ovf_err(ovf_err), .udf_err(udf_err)
    );

    always #5 wclk = ~wclk;

    logic [7:0] mem_m [0:7];
    logic [7:0] rdata;
    always @(posedge wclk) begin
        if (mem_wen) mem_m[mem_waddr] <= mem_wdata;
    end
    assign rdata = mem_m[mem_raddr];

    typedef struct {
        logic       r0;
        logic [7:0] d0;
        logic       r1;
        logic [7:0] d1;
        logic       rinc;
        logic       fl;
        logic [1:0] egnt;
        logic [3:0] ecnt;
        logic       eovf;
        logic       eudf;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] sb[$];
    int         n_vec = 0;
    int         n_err = 0;
    int         mark_arb;
    logic [3:0] m_wptr, m_rptr, m_cnt;

    function automatic void add(input int r0, input int d0, input int r1, input int d1,
                                input int ri, input int fl, input int egnt,
                                input int ecnt, input int eovf, input int eudf);
        vec_t v;
        v.r0 = 1'(r0);   v.d0 = 8'(d0);  v.r1 = 1'(r1);     v.d1 = 8'(d1);
        v.rinc = 1'(ri); v.fl = 1'(fl);  v.egnt = 2'(egnt); v.ecnt = 4'(ecnt);
        v.eovf = 1'(eovf); v.eudf = 1'(eudf);
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        vec_t       v;
        logic [7:0] exp_d;
        logic [7:0] arb_pat [0:3];

        // stimulus table
        for (int k = 0; k < 8; k++) add(1, 8'h10 + k, 0, 0, 0, 0, 1, k + 1, 0, 0);
        add(1, 8'h18, 0, 0, 0, 0, 0, 8, 1, 0);
        add(1, 8'h18, 0, 0, 0, 0, 0, 8, 1, 0);
        add(1, 8'h18, 0, 0, 1, 0, 0, 7, 1, 0);
        add(1, 8'h18, 0, 0, 0, 0, 1, 8, 0, 0);
        for (int k = 0; k < 8; k++) add(0, 0, 0, 0, 1, 0, 0, 7 - k, 0, 0);
        add(0, 0, 0, 0, 1, 0, 0, 0, 0, 1);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) add(1, 8'hA0, 1, 8'hB1, 0, 0, (k % 2 == 0) ? 1 : 2, k + 1, 0, 0);
        mark_arb = vecs.size() - 1;
        add(0, 0, 0, 0, 1, 0, 0, 3, 0, 0);
        add(0, 0, 1, 8'hC3, 1, 0, 2, 3, 0, 0);
        for (int k = 0; k < 3; k++) add(0, 0, 0, 0, 1, 0, 0, 2 - k, 0, 0);
        add(1, 8'hD4, 0, 0, 1, 0, 1, 1, 0, 1);
        add(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 5; k++) add(0, 0, 1, 8'h50 + k, 0, 0, 2, k + 1, 0, 0);
        add(1, 8'hE0, 0, 0, 1, 1, 0, 0, 0, 0);
        add(1, 8'h60, 0, 0, 0, 0, 1, 1, 0, 0);
        add(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        arb_pat[0] = 8'hA0; arb_pat[1] = 8'hB1; arb_pat[2] = 8'hA0; arb_pat[3] = 8'hB1;

        // reset: outputs held at reset values even with a request present
        rst = 1'b0; flush = 1'b0; rinc = 1'b0;
        req0 = 1'b1; wdata0 = 8'hAA; req1 = 1'b0; wdata1 = 8'h55;
        #2;
        chk("rst_gnt", {gnt1, gnt0}, 2'b00);
        chk("rst_wen", mem_wen, 1'b0);
        chk("rst_wdata", mem_wdata, 8'h00);
        repeat (2) @(posedge wclk);
        #1;
        rst = 1'b1; req0 = 1'b0; wdata0 = 8'h00;
        #1;
        chk("rel_empty", empty, 1'b1);
        chk("rel_full", full, 1'b0);
        chk("rel_count", count, 4'd0);
        chk("rel_gnt", {gnt1, gnt0}, 2'b00);
        chk("rel_waddr", mem_waddr, 3'd0);
        chk("rel_err", {ovf_err, udf_err}, 2'b00);
        @(posedge wclk);
        #1;
        m_wptr = 4'd0; m_rptr = 4'd0;

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            req0 = v.r0; wdata0 = v.d0; req1 = v.r1; wdata1 = v.d1;
            rinc = v.rinc; flush = v.fl;
            #3;
            chk("gnt", {gnt1, gnt0}, v.egnt);
            chk("wen", mem_wen, |v.egnt);
            chk("waddr", mem_waddr, m_wptr[2:0]);
            chk("raddr", mem_raddr, m_rptr[2:0]);
            if (v.egnt != 2'b00) begin
                exp_d = v.egnt[1] ? v.d1 : v.d0;
                chk("wdata", mem_wdata, exp_d);
                sb.push_back(exp_d);
            end
            m_cnt = m_wptr - m_rptr;
            if (v.fl) begin
                m_wptr = 4'd0; m_rptr = 4'd0;
                sb.delete();
            end else begin
                if (v.rinc && m_cnt != 4'd0) begin
                    if (sb.size() == 0) begin
                        n_vec++; n_err++;
                        $display("FAIL sb_empty: pop with no expected data at %0t", $time);
                    end else begin
                        exp_d = sb.pop_front();
                        chk("rdata", rdata, exp_d);
                    end
                    m_rptr = m_rptr + 4'd1;
                end
                if (v.egnt != 2'b00) m_wptr = m_wptr + 4'd1;
            end
            @(posedge wclk);
            #1;
            chk("count", count, v.ecnt);
            chk("full", full, v.ecnt == 4'd8);
            chk("empty", empty, v.ecnt == 4'd0);
            chk("ovf", ovf_err, v.eovf);
            chk("udf", udf_err, v.eudf);
            if (i == mark_arb) begin
                for (int a = 0; a < 4; a++) chk("arb_mem", mem_m[a], arb_pat[a]);
            end
        end

        // asynchronous reset in the middle of a write burst
        req0 = 1'b1; wdata0 = 8'h77; req1 = 1'b0; rinc = 1'b0; flush = 1'b0;
        repeat (2) begin
            @(posedge wclk);
            #1;
        end
        chk("burst_count", count, 4'd2);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_count", count, 4'd0);
        chk("arst_empty", empty, 1'b1);
        chk("arst_full", full, 1'b0);
        chk("arst_gnt", {gnt1, gnt0}, 2'b00);
        chk("arst_wen", mem_wen, 1'b0);
        chk("arst_wdata", mem_wdata, 8'h00);
        chk("arst_addr", {mem_waddr, mem_raddr}, 6'd0);
        chk("arst_err", {ovf_err, udf_err}, 2'b00);
        @(posedge wclk);
        #1;
        rst = 1'b1; req0 = 1'b0;
        @(posedge wclk);
        #1;
        chk("post_count", count, 4'd0);
        chk("post_empty", empty, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
